// File: rtl/axi_if_rd_burst_sched_if.sv
// ---------------------------------------------------------------------------
// axi_if_rd_burst_sched_if
// AXI4 read-address channel plus the snooped R-channel handshake used by
// axi_if_rd_burst_sched.
//   master modport : burst scheduler side (drives AR, observes R handshake)
//   slave  modport : AXI slave side (accepts AR, returns R)
// Signals: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//          arqos, arregion, arvalid, arready, rvalid, rready, rlast, rresp
// ---------------------------------------------------------------------------
interface axi_if_rd_burst_sched_if #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_ID_W   = 4
);
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [1:0]            rresp;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    input  arready, rvalid, rready, rlast, rresp
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid, rready,
    output arready, rvalid, rlast, rresp
  );
endinterface

// File: rtl/axi_if_rd_burst_sched.sv
// ---------------------------------------------------------------------------
// axi_if_rd_burst_sched
// Splits one linear read request {byte address, byte size} into AXI4 INCR
// read bursts that never cross a 4 KiB page and never exceed BLEN_MAX beats.
// The R channel is snooped (rlast) to count in-flight bursts; done pulses
// once every burst has returned its last beat.
//
// Ports:
//   clk, s_rst          clock, synchronous active-high reset
//   req_vld / req_rdy   request handshake (req_rdy only while idle)
//   req_add, req_size   start byte address / byte count (DATA_BYTES aligned)
//   busy                high whenever a request is in progress
//   done                one-cycle pulse when the request has fully returned
//   err                 sticky non-OKAY RRESP flag
//   m_axi               AR channel master + snooped R handshake
//
// Optional feature macro: AXI_IF_RD_BURST_SCHED_ERR_EN
//   defined   : err latches on any non-OKAY response beat while busy,
//               cleared by the next request acceptance or reset
//   undefined : rresp is ignored, err is tied low
// ---------------------------------------------------------------------------
module axi_if_rd_burst_sched #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_DATA_W = 512,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ID     = 0,
  parameter int BLEN_MAX   = 64,
  parameter int OUTSTD_MAX = 16,
  parameter int REQ_SIZE_W = 32
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [AXI_ADDR_W-1:0] req_add,
  input  logic [REQ_SIZE_W-1:0] req_size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axi_if_rd_burst_sched_if.master m_axi
);

  localparam int DATA_BYTES = AXI_DATA_W / 8;
  localparam int SIZE_LOG2  = $clog2(DATA_BYTES);
  localparam int PAGE_BYTES = 4096;
  localparam int OUT_W      = $clog2(OUTSTD_MAX + 1);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [AXI_ADDR_W-1:0] addr;
  logic [REQ_SIZE_W-1:0] rem_beats;
  logic [8:0]            beats;
  logic [OUT_W-1:0]      outstanding;
  logic                  arvalid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  req_rdy_q;
  logic                  done_q;

  logic [12:0]           pg_beats;
  logic [8:0]            lim_beats;
  logic [8:0]            calc_beats;
  logic                  ar_hs;
  logic                  r_last_hs;
  logic                  can_issue;

  assign ar_hs     = arvalid_q & m_axi.arready;
  assign r_last_hs = m_axi.rvalid & m_axi.rready & m_axi.rlast;
  assign can_issue = (outstanding < OUT_W'(OUTSTD_MAX));

  // Burst length: smallest of remaining beats, BLEN_MAX and beats left in
  // the current 4 KiB page (a page-aligned address yields a full page).
  always_comb begin
    pg_beats   = 13'((13'(PAGE_BYTES) - {1'b0, addr[11:0]}) >> SIZE_LOG2);
    lim_beats  = (pg_beats < 13'(BLEN_MAX)) ? pg_beats[8:0] : 9'(BLEN_MAX);
    calc_beats = (rem_beats < REQ_SIZE_W'(lim_beats)) ? rem_beats[8:0] : lim_beats;
  end

  // Scheduler FSM; addr/rem_beats/beats are datapath and carry no reset.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      req_rdy_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld && req_rdy_q) begin
            addr      <= req_add;
            rem_beats <= req_size >> SIZE_LOG2;
            req_rdy_q <= 1'b0;
            state     <= CALC;
          end else begin
            req_rdy_q <= 1'b1;
          end
        end
        CALC: begin
          araddr_q  <= addr;
          arlen_q   <= 8'(calc_beats - 9'd1);
          beats     <= calc_beats;
          arvalid_q <= can_issue;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            addr      <= addr + (AXI_ADDR_W'(beats) << SIZE_LOG2);
            rem_beats <= rem_beats - REQ_SIZE_W'(beats);
            state     <= (rem_beats == REQ_SIZE_W'(beats)) ? DRAIN : CALC;
          end else if (!arvalid_q && can_issue) begin
            // Once raised, arvalid is only dropped by the handshake above.
            arvalid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight burst count; a simultaneous accept and last beat cancel out.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      outstanding <= '0;
    end else if (ar_hs && !r_last_hs) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!ar_hs && r_last_hs) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

`ifdef AXI_IF_RD_BURST_SCHED_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req_vld && req_rdy_q) begin
      err_q <= 1'b0;
    end else if (state != IDLE && m_axi.rvalid && m_axi.rready &&
                 m_axi.rresp != 2'b00) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi.rresp;
  assign err = 1'b0;
`endif

  always @(posedge clk) begin
    if (!s_rst) begin
      assert (!(r_last_hs && !ar_hs && outstanding == '0));
      assert (outstanding <= OUT_W'(OUTSTD_MAX));
      if (state == IDLE && req_vld && req_rdy_q) begin
        assert (req_size != '0 &&
                (req_size % REQ_SIZE_W'(DATA_BYTES)) == '0 &&
                (req_add % AXI_ADDR_W'(DATA_BYTES)) == '0);
      end
    end
  end

  assign req_rdy        = req_rdy_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign m_axi.arid     = AXI_ID_W'(AXI_ID);
  assign m_axi.araddr   = araddr_q;
  assign m_axi.arlen    = arlen_q;
  assign m_axi.arsize   = 3'(SIZE_LOG2);
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'b0011;
  assign m_axi.arprot   = 3'b000;
  assign m_axi.arqos    = 4'b0000;
  assign m_axi.arregion = 4'b0000;
  assign m_axi.arvalid  = arvalid_q;

endmodule

// File: tb/tb_axi_if_rd_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_axi_if_rd_burst_sched
// Directed bench for axi_if_rd_burst_sched. Two instances share the clock:
// u_dut0 with default parameters and u_dut1 with OUTSTD_MAX=2. 'sel' routes
// the stimulus to one instance and picks which outputs are observed.
// ---------------------------------------------------------------------------
module tb_axi_if_rd_burst_sched;

  localparam bit ERR_EN =
`ifdef AXI_IF_RD_BURST_SCHED_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_vld = 1'b0;
  logic [63:0] req_add = '0;
  logic [31:0] req_size = '0;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready = 1'b0;
  logic        rlast = 1'b0;
  logic [1:0]  rresp = 2'b00;

  logic req_rdy0, busy0, done0, err0;
  logic req_rdy1, busy1, done1, err1;

  logic        o_req_rdy, o_busy, o_done, o_err, o_arvalid;
  logic [63:0] o_araddr;
  logic [7:0]  o_arlen;

  int n_chk = 0;
  int n_err = 0;
  int ar_cnt = 0;
  int done_cnt = 0;
  logic [63:0] ar_log [0:63];

  always #5 clk = ~clk;

  axi_if_rd_burst_sched_if #(.AXI_ADDR_W(64), .AXI_ID_W(4)) if0 ();
  axi_if_rd_burst_sched_if #(.AXI_ADDR_W(64), .AXI_ID_W(4)) if1 ();

  assign if0.arready = !sel & arready;
  assign if0.rvalid  = !sel & rvalid;
  assign if0.rready  = !sel & rready;
  assign if0.rlast   = !sel & rlast;
  assign if0.rresp   = sel ? 2'b00 : rresp;
  assign if1.arready = sel & arready;
  assign if1.rvalid  = sel & rvalid;
  assign if1.rready  = sel & rready;
  assign if1.rlast   = sel & rlast;
  assign if1.rresp   = sel ? rresp : 2'b00;

  axi_if_rd_burst_sched u_dut0 (
    .clk      (clk),
    .s_rst    (s_rst),
    .req_vld  (!sel & req_vld),
    .req_rdy  (req_rdy0),
    .req_add  (req_add),
    .req_size (req_size),
    .busy     (busy0),
    .done     (done0),
    .err      (err0),
    .m_axi    (if0)
  );

  axi_if_rd_burst_sched #(.OUTSTD_MAX(2)) u_dut1 (
    .clk      (clk),
    .s_rst    (s_rst),
    .req_vld  (sel & req_vld),
    .req_rdy  (req_rdy1),
    .req_add  (req_add),
    .req_size (req_size),
    .busy     (busy1),
    .done     (done1),
    .err      (err1),
    .m_axi    (if1)
  );

  always_comb begin
    if (sel) begin
      o_req_rdy = req_rdy1; o_busy = busy1; o_done = done1; o_err = err1;
      o_arvalid = if1.arvalid; o_araddr = if1.araddr; o_arlen = if1.arlen;
    end else begin
      o_req_rdy = req_rdy0; o_busy = busy0; o_done = done0; o_err = err0;
      o_arvalid = if0.arvalid; o_araddr = if0.araddr; o_arlen = if0.arlen;
    end
  end

  // Record every accepted AR and every done pulse of the observed instance.
  always @(posedge clk) begin
    if (o_arvalid && arready) begin
      ar_log[ar_cnt % 64] <= o_araddr;
      ar_cnt <= ar_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req(input logic [63:0] a, input logic [31:0] s);
    int t = 0;
    while (!o_req_rdy && t < 50) begin @(negedge clk); t++; end
    chk_val("req_rdy_wait", o_req_rdy, 1);
    req_vld = 1'b1; req_add = a; req_size = s;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic wait_ar(input string tag);
    int t = 0;
    while (!o_arvalid && t < 50) begin @(negedge clk); t++; end
    chk_val(tag, o_arvalid, 1);
  endtask

  task automatic take_ar;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic r_beat(input logic last, input logic [1:0] resp);
    rvalid = 1'b1; rready = 1'b1; rlast = last; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!o_done && t < 50) begin @(negedge clk); t++; end
    chk_val(tag, o_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int t;

    // Reset values and constant AR fields
    step(3);
    chk_val("rst_req_rdy", o_req_rdy, 0);
    chk_val("rst_busy", o_busy, 0);
    chk_val("rst_done", o_done, 0);
    chk_val("rst_err", o_err, 0);
    chk_val("rst_arvalid", o_arvalid, 0);
    chk_val("rst_araddr", o_araddr, 0);
    chk_val("rst_arlen", o_arlen, 0);
    chk_val("rst_outstd", u_dut0.outstanding, 0);
    chk_val("arsize", if0.arsize, 6);
    chk_val("arburst", if0.arburst, 1);
    chk_val("arcache", if0.arcache, 3);
    chk_val("arid", if0.arid, 0);
    chk_val("arprot", if0.arprot, 0);
    s_rst = 1'b0;
    step(2);
    chk_val("rdy_after_rst", o_req_rdy, 1);

    // Page split: 0xFC0 + 256 bytes -> 1 beat then 3 beats at 0x1000
    send_req(64'h0FC0, 32'd256);
    wait_ar("A_ar0_vld");
    chk_val("A_ar0_addr", o_araddr, 64'h0FC0);
    chk_val("A_ar0_len", o_arlen, 0);
    chk_val("A_busy", o_busy, 1);
    take_ar();
    wait_ar("A_ar1_vld");
    chk_val("A_ar1_addr", o_araddr, 64'h1000);
    chk_val("A_ar1_len", o_arlen, 2);
    take_ar();
    step(3);
    chk_val("A_no_extra_ar", o_arvalid, 0);
    r_beat(1'b1, 2'b00);
    step(2);
    chk_val("A_no_early_done", o_done, 0);
    r_beat(1'b1, 2'b00);
    wait_done("A_done");
    chk_val("A_rdy_in_done", o_req_rdy, 0);
    chk_val("A_busy_in_done", o_busy, 0);
    step(1);
    chk_val("A_rdy_after", o_req_rdy, 1);
    chk_val("A_done_pulse", o_done, 0);

    // 8192 bytes from 0: two 64-beat bursts; first AR held off for 10 cycles
    send_req(64'h0, 32'd8192);
    wait_ar("B_ar0_vld");
    for (int i = 0; i < 10; i++) begin
      chk_val("B_hold_vld", o_arvalid, 1);
      chk_val("B_hold_addr", o_araddr, 64'h0);
      chk_val("B_hold_len", o_arlen, 63);
      @(negedge clk);
    end
    take_ar();
    wait_ar("B_ar1_vld");
    chk_val("B_ar1_addr", o_araddr, 64'h1000);
    chk_val("B_ar1_len", o_arlen, 63);
    take_ar();
    r_beat(1'b1, 2'b00);
    r_beat(1'b1, 2'b00);
    wait_done("B_done");

    // AR accept and last beat in the same cycle with one burst in flight
    send_req(64'h0, 32'd8192);
    wait_ar("E_ar0_vld");
    take_ar();
    wait_ar("E_ar1_vld");
    chk_val("E_outstd_pre", u_dut0.outstanding, 1);
    arready = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_val("E_outstd_hold", u_dut0.outstanding, 1);
      chk_val("E_no_done", o_done, 0);
      @(negedge clk);
    end
    r_beat(1'b1, 2'b00);
    wait_done("E_done");

    // OUTSTD_MAX=2 instance: 4 bursts, R withheld
    sel = 1'b1;
    step(2);
    arready = 1'b1;
    base = ar_cnt;
    dbase = done_cnt;
    send_req(64'h0, 32'd16384);
    step(15);
    chk_val("D_ar_count2", ar_cnt - base, 2);
    chk_val("D_arvalid_low", o_arvalid, 0);
    chk_val("D_log0", ar_log[base % 64], 64'h0);
    chk_val("D_log1", ar_log[(base + 1) % 64], 64'h1000);
    r_beat(1'b1, 2'b00);
    step(8);
    chk_val("D_ar_count3", ar_cnt - base, 3);
    chk_val("D_log2", ar_log[(base + 2) % 64], 64'h2000);
    r_beat(1'b1, 2'b00);
    step(8);
    chk_val("D_ar_count4", ar_cnt - base, 4);
    chk_val("D_log3", ar_log[(base + 3) % 64], 64'h3000);
    r_beat(1'b1, 2'b00);
    step(4);
    chk_val("D_no_done_3", done_cnt - dbase, 0);
    r_beat(1'b1, 2'b00);
    wait_done("D_done");
    arready = 1'b0;
    sel = 1'b0;
    step(2);

    // Reset in ISSUE with 3 bursts outstanding
    base = ar_cnt;
    arready = 1'b1;
    send_req(64'h0, 32'd16384);
    t = 0;
    while ((ar_cnt - base) < 3 && t < 50) begin @(negedge clk); t++; end
    arready = 1'b0;
    chk_val("F_three_ars", ar_cnt - base, 3);
    wait_ar("F_ar3_vld");
    chk_val("F_outstd3", u_dut0.outstanding, 3);
    s_rst = 1'b1;
    @(negedge clk);
    chk_val("F_arvalid", o_arvalid, 0);
    chk_val("F_busy", o_busy, 0);
    chk_val("F_rdy_in_rst", o_req_rdy, 0);
    chk_val("F_outstd0", u_dut0.outstanding, 0);
    s_rst = 1'b0;
    step(2);
    chk_val("F_rdy_after", o_req_rdy, 1);

    // SLVERR on beat 2 of a 4-beat burst
    send_req(64'h0, 32'd256);
    wait_ar("G_ar_vld");
    chk_val("G_arlen", o_arlen, 3);
    take_ar();
    r_beat(1'b0, 2'b00);
    r_beat(1'b0, 2'b10);
    chk_val("G_err_set", o_err, ERR_EN);
    r_beat(1'b0, 2'b00);
    r_beat(1'b1, 2'b00);
    wait_done("G_done");
    chk_val("G_err_at_done", o_err, ERR_EN);
    step(1);
    chk_val("G_err_sticky", o_err, ERR_EN);
    send_req(64'h2000, 32'd64);
    chk_val("G_err_clr", o_err, 0);
    wait_ar("G2_ar_vld");
    chk_val("G2_addr", o_araddr, 64'h2000);
    chk_val("G2_len", o_arlen, 0);
    take_ar();
    r_beat(1'b1, 2'b00);
    wait_done("G2_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
